// File: rtl/pipe_stage_chain_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// Provides the stage-state encoding, counter width and small width/counter helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  localparam int PERF_W = 32;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  // Saturating increment so counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (v == {PERF_W{1'b1}}) begin
      return v;
    end else begin
      return v + PERF_W'(1);
    end
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic pipeline stage: main register plus optional skid entry.
// With SKID=1 the upstream ready is purely registered; with SKID=0 it passes out_ready through.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_r;
  stage_state_e     state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             accept_s;
  logic             emit_s;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_r != ST_SKID);
    end else begin : g_noskid
      assign in_ready = (state_r == ST_EMPTY) || out_ready;
    end
  endgenerate

  assign out_valid = (state_r != ST_EMPTY);
  assign out_data  = main_r;
  assign accept_s  = in_valid && in_ready;
  assign emit_s    = out_valid && out_ready;

  // Next-state and data selection; flush wins over any handshake.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = NOP_VALUE;
      skid_nxt_s  = NOP_VALUE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && emit_s) begin
            main_nxt_s = in_data;
          end else if (accept_s) begin
            // Only reachable with SKID=1: park the new word behind the main entry.
            state_nxt_s = ST_SKID;
            skid_nxt_s  = in_data;
          end else if (emit_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (emit_s) begin
            state_nxt_s = ST_FULL;
            main_nxt_s  = skid_r;
            skid_nxt_s  = NOP_VALUE;
          end else begin
            state_nxt_s = ST_SKID;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = NOP_VALUE;
          skid_nxt_s  = NOP_VALUE;
        end
      endcase
    end
  end

  // Stage state and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      main_r  <= NOP_VALUE;
      skid_r  <= NOP_VALUE;
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH stages, bubble injection, flush and occupancy.
// Optional PIPE_STAGE_CHAIN_PERF_EN adds stall/bubble/flush performance counters.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_bubble,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  ,
  output logic [PERF_W-1:0]                stall_cnt,
  output logic [PERF_W-1:0]                bubble_cnt,
  output logic [PERF_W-1:0]                flush_cnt
`endif
);

  localparam int OCC_W = occ_width(DEPTH);

  logic             vld_s [DEPTH+1];
  logic             rdy_s [DEPTH+1];
  logic [WIDTH-1:0] dat_s [DEPTH+1];
  logic [OCC_W-1:0] occ_r;
  logic             inc_s;
  logic             dec_s;

  // A bubble stands in for upstream data; flush blocks anything entering stage 0.
  assign vld_s[0]     = !flush && (in_bubble || in_valid);
  assign dat_s[0]     = in_bubble ? NOP_VALUE : in_data;
  assign rdy_s[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH     (WIDTH),
      .SKID      (SKID),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld_s[i]),
      .in_ready  (rdy_s[i]),
      .in_data   (dat_s[i]),
      .out_valid (vld_s[i+1]),
      .out_ready (rdy_s[i+1]),
      .out_data  (dat_s[i+1])
    );
  end

  assign in_ready  = rdy_s[0] && !flush && !in_bubble && !rst;
  assign out_valid = vld_s[DEPTH];
  assign out_data  = dat_s[DEPTH];
  assign inc_s     = vld_s[0] && rdy_s[0];
  assign dec_s     = out_valid && out_ready;
  assign occupancy = occ_r;

  // Entry count across all main and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (inc_s && !dec_s) begin
      occ_r <= occ_r + OCC_W'(1);
    end else if (dec_s && !inc_s) begin
      occ_r <= occ_r - OCC_W'(1);
    end else begin
      occ_r <= occ_r;
    end
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [PERF_W-1:0] stall_cnt_r;
  logic [PERF_W-1:0] bubble_cnt_r;
  logic [PERF_W-1:0] flush_cnt_r;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r  <= {PERF_W{1'b0}};
      bubble_cnt_r <= {PERF_W{1'b0}};
      flush_cnt_r  <= {PERF_W{1'b0}};
    end else begin
      if (out_valid && !out_ready) stall_cnt_r <= sat_inc(stall_cnt_r);
      if (in_bubble && !flush && rdy_s[0]) bubble_cnt_r <= sat_inc(bubble_cnt_r);
      if (flush) flush_cnt_r <= sat_inc(flush_cnt_r);
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`endif

endmodule
